// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counting timer: register
// offsets, FSM state codes, mode codes and CTRL bit positions.
package timer_counter_pkg;

  localparam int DEV_ADDR_WD = 4;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } tcState_e;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Reserved modes 2 and 3 collapse onto one-shot behaviour.
  function automatic logic [1:0] effectiveMode(input logic [1:0] mode);
    return (mode == MODE_PERIODIC) ? MODE_PERIODIC : MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// 32-bit down-counting timer in one bridge device slot: CTRL/PRESET/COUNT
// registers, a four-state count FSM and a maskable level interrupt.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int ADDR_WD = DEV_ADDR_WD,
  parameter int CNT_WD  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_WD-1:0] DevAddr,
  input  logic               DevWE,
  input  logic [31:0]        DevWD,
  output logic [31:0]        DevRD,
  output logic               IRQ
);

  tcState_e           state;
  tcState_e           nextState;
  logic               ctrlEn;
  logic [1:0]         ctrlMode;
  logic               ctrlIm;
  logic [CNT_WD-1:0]  presetReg;
  logic [CNT_WD-1:0]  countReg;
  logic               intFlag;
  logic [1:0]         regSel;
  logic               wrCtrl;
  logic               wrPreset;
  logic               countZero;
  logic               loadCount;
  logic               decCount;
  logic               setFlag;
  logic               pulseClr;
  logic               hwClrEn;
  logic [31:0]        ctrlWord;
  logic               unusedAddrBits;

  assign regSel         = DevAddr[3:2];
  assign unusedAddrBits = ^DevAddr[1:0];
  assign wrCtrl         = DevWE && (regSel == TC_CTRL);
  assign wrPreset       = DevWE && (regSel == TC_PRESET);
  assign countZero      = (countReg == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE: if (ctrlEn) nextState = S_LOAD;
      S_LOAD: nextState = S_CNT;
      S_CNT: begin
        if (!ctrlEn)        nextState = S_IDLE;
        else if (countZero) nextState = S_INT;
      end
      S_INT: nextState = (effectiveMode(ctrlMode) == MODE_PERIODIC) ? S_LOAD : S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_comb begin
    loadCount = 1'b0;
    decCount  = 1'b0;
    setFlag   = 1'b0;
    pulseClr  = 1'b0;
    hwClrEn   = 1'b0;
    case (state)
      S_LOAD: loadCount = 1'b1;
      S_CNT: begin
        if (ctrlEn) begin
          if (countZero) setFlag  = 1'b1;
          else           decCount = 1'b1;
        end
      end
      S_INT: begin
        if (effectiveMode(ctrlMode) == MODE_PERIODIC) pulseClr = 1'b1;
        else                                          hwClrEn  = 1'b1;
      end
      default: ;
    endcase
  end

  // Software CTRL writes override the hardware En clear; a flag set beats any clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrlEn    <= 1'b0;
      ctrlMode  <= MODE_ONESHOT;
      ctrlIm    <= 1'b0;
      presetReg <= '0;
      countReg  <= '0;
      intFlag   <= 1'b0;
    end else begin
      if (wrCtrl) begin
        ctrlEn   <= DevWD[CTRL_EN];
        ctrlMode <= DevWD[CTRL_MODE_HI:CTRL_MODE_LO];
        ctrlIm   <= DevWD[CTRL_IM];
      end else if (hwClrEn) begin
        ctrlEn <= 1'b0;
      end
      if (wrPreset) presetReg <= DevWD[CNT_WD-1:0];
      if (loadCount)     countReg <= presetReg;
      else if (decCount) countReg <= countReg - CNT_WD'(1);
      if (setFlag)                              intFlag <= 1'b1;
      else if (wrCtrl || wrPreset || pulseClr)  intFlag <= 1'b0;
    end
  end

  always_comb begin
    ctrlWord                            = '0;
    ctrlWord[CTRL_EN]                   = ctrlEn;
    ctrlWord[CTRL_MODE_HI:CTRL_MODE_LO] = ctrlMode;
    ctrlWord[CTRL_IM]                   = ctrlIm;
  end

  always_comb begin
    case (regSel)
      TC_CTRL:   DevRD = ctrlWord;
      TC_PRESET: DevRD = 32'(presetReg);
      TC_COUNT:  DevRD = 32'(countReg);
      default:   DevRD = 32'd0;
    endcase
  end

  assign IRQ = ctrlIm & intFlag;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: timeline-based reference model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  DevAddr;
  logic        DevWE;
  logic [31:0] DevWD;
  logic [31:0] DevRD;
  logic        IRQ;

  int vectors = 0;
  int miscompares = 0;
  bit checkOn = 1'b0;

  timer_counter dut (
    .clk    (clk),
    .reset  (reset),
    .DevAddr(DevAddr),
    .DevWE  (DevWE),
    .DevWD  (DevWD),
    .DevRD  (DevRD),
    .IRQ    (IRQ)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers plus a timeline of scheduled
  // edges (reload edge, interrupt edge, edge after interrupt).
  logic        mEn = 0, mIm = 0, mFlag = 0;
  logic [1:0]  mMode = 0;
  logic [31:0] mPreset = 0, mCount = 0;
  longint cyc = 0, loadEdge = -1, baseEdge = 0, baseVal = 0, intEdge = -1, afterInt = -1;
  bit counting = 0;

  task automatic mReset();
    mEn = 0; mIm = 0; mFlag = 0; mMode = 0; mPreset = 0; mCount = 0;
    loadEdge = -1; intEdge = -1; afterInt = -1; counting = 0;
  endtask

  task automatic mStep();
    logic wrC, wrP;
    logic [31:0] nCount;
    bit setF, clrP, hwClr;
    cyc++;
    wrC = DevWE && (DevAddr[3:2] == 2'd0);
    wrP = DevWE && (DevAddr[3:2] == 2'd1);
    nCount = mCount; setF = 0; clrP = 0; hwClr = 0;
    if (loadEdge == cyc) begin
      nCount = mPreset; baseEdge = cyc; baseVal = longint'(mPreset);
      intEdge = cyc + longint'(mPreset) + 1; counting = 1; loadEdge = -1;
    end else if (counting) begin
      if (!mEn) counting = 0;
      else if (cyc == intEdge) begin setF = 1; counting = 0; afterInt = cyc + 1; end
      else nCount = 32'(baseVal - (cyc - baseEdge));
    end else if (afterInt == cyc) begin
      afterInt = -1;
      if (mMode == 2'd1) begin clrP = 1; loadEdge = cyc + 1; end
      else hwClr = 1;
    end else if (mEn) begin
      loadEdge = cyc + 1;
    end
    if (wrC) begin mEn = DevWD[0]; mMode = DevWD[2:1]; mIm = DevWD[3]; end
    else if (hwClr) mEn = 0;
    if (wrP) mPreset = DevWD;
    mCount = nCount;
    if (setF) mFlag = 1;
    else if (wrC || wrP || clrP) mFlag = 0;
  endtask

  function automatic logic [31:0] mRead(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {28'd0, mIm, mMode, mEn};
      2'd1:    return mPreset;
      2'd2:    return mCount;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) mReset();
    else       mStep();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      chk("model_irq", {31'd0, IRQ}, {31'd0, mIm & mFlag});
      chk("model_rd", DevRD, mRead(DevAddr));
    end
  end

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    DevAddr = {r, 2'b00}; DevWD = d; DevWE = 1'b1;
    @(posedge clk); #1;
    DevWE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rdChk(input string n, input logic [1:0] r, input logic [31:0] e);
    DevAddr = {r, 2'b00}; #1;
    chk(n, DevRD, e);
  endtask

  task automatic irqChk(input string n, input logic e);
    chk(n, {31'd0, IRQ}, {31'd0, e});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    DevWE = 0; DevAddr = 0; DevWD = 0;
    idle(2);
    reset = 1'b0;
    checkOn = 1'b1;
    irqChk("reset_irq", 1'b0);
    rdChk("reset_ctrl", 2'd0, 32'd0);
    rdChk("reset_preset", 2'd1, 32'd0);
    rdChk("reset_count", 2'd2, 32'd0);

    // Reset mid-count takes effect without a clock edge.
    idle(1);
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    idle(10);
    #1 reset = 1'b1;
    #1 irqChk("midreset_irq", 1'b0);
    rdChk("midreset_ctrl", 2'd0, 32'd0);
    rdChk("midreset_preset", 2'd1, 32'd0);
    rdChk("midreset_count", 2'd2, 32'd0);
    reset = 1'b0;
    idle(3);

    // One-shot, PRESET=5.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    idle(7);  irqChk("oneshot_irq_e7", 1'b0);
    idle(1);  irqChk("oneshot_irq_e8", 1'b1);
    idle(1);  rdChk("oneshot_ctrl", 2'd0, 32'h8);
    irqChk("oneshot_irq_hold", 1'b1);
    idle(3);  irqChk("oneshot_irq_hold2", 1'b1);
    wr(2'd0, 32'h8);
    irqChk("oneshot_irq_clr", 1'b0);
    idle(2);

    // Periodic, PRESET=3: period 6, COUNT 3,2,1,0 between pulses.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int t = 1; t <= 24; t++) begin
      idle(1);
      irqChk("periodic_irq", (t >= 6 && t % 6 == 0));
      if (t >= 2) rdChk("periodic_count", 2'd2, ((t % 6) >= 2) ? 32'(5 - (t % 6)) : 32'd0);
    end
    wr(2'd0, 32'h0);
    idle(6);

    // Masked interrupt with PRESET=0; CTRL write clears the hidden flag.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    idle(3);  irqChk("mask_irq_e3", 1'b0);
    idle(1);  rdChk("mask_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    irqChk("mask_irq_after", 1'b0);
    idle(2);  irqChk("mask_irq_later", 1'b0);

    // PRESET=0 unmasked: set beats clear, software write beats En clear.
    wr(2'd0, 32'h9);
    idle(2);
    wr(2'd1, 32'd0);
    irqChk("setwins_irq", 1'b1);
    wr(2'd0, 32'h9);
    rdChk("swwins_ctrl", 2'd0, 32'h9);
    irqChk("swwins_irq", 1'b0);
    wr(2'd0, 32'h0);
    idle(4);

    // Register access corner cases.
    wr(2'd2, 32'hFFFF_FFFF);
    rdChk("count_ro", 2'd2, 32'd0);
    wr(2'd3, 32'hFFFF_FFFF);
    rdChk("rsvd_rd", 2'd3, 32'd0);
    wr(2'd0, 32'hFFFF_FFFF);
    rdChk("ctrl_mask", 2'd0, 32'hF);
    wr(2'd0, 32'h0);
    idle(5);

    // PRESET change mid-count only affects the next reload.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'hB);
    idle(4);
    wr(2'd1, 32'd2);
    rdChk("presetmid_count", 2'd2, 32'd7);
    rdChk("presetmid_preset", 2'd1, 32'd2);
    idle(10);
    rdChk("presetmid_reload", 2'd2, 32'd2);
    wr(2'd0, 32'h0);
    idle(5);

    // Disable mid-count holds COUNT; re-enable reloads.
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h1);
    idle(9);
    wr(2'd0, 32'h0);
    idle(5);
    rdChk("disable_hold", 2'd2, 32'd12);
    wr(2'd0, 32'h1);
    idle(2);
    rdChk("reenable_reload", 2'd2, 32'd20);
    wr(2'd0, 32'h0);
    idle(3);

    // Randomized traffic checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      DevAddr = 4'($urandom);
      DevWE = 1'b0;
      if (r < 2) begin
        reset = 1'b1; #2; reset = 1'b0;
      end else if (r < 27) begin
        DevWE = 1'b1;
        if (DevAddr[3:2] == 2'd1)
          DevWD = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
        else
          DevWD = $urandom;
      end
      @(posedge clk); #1;
      DevWE = 1'b0;
    end

    @(negedge clk);
    checkOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
